exec_mul_seq: RTL and testbench
===============================

# exec_mul_seq

Iterative shift-add multiply sequencer for the execute stage. When a MUL reaches execute, the block takes ownership of the execute ALU and drives it with add operations, one multiplier bit per cycle. It accumulates the partial product, stalls the rest of the pipeline while it runs, and presents the low 64 bits of the product when done. It sits beside the execute datapath: its ALU operand and control outputs feed the execute-stage operand muxes, and its stall output goes to the pipeline control.

## Interface
- `N`, 64: operand and result width.
- `ALU_ADD`, 4'b0010: AluControl code driven while the block owns the ALU.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `mul_E` in 1: a MUL instruction is present in execute (start request).
- `flush_E` in 1: the pipeline is squashing execute; abort any operation.
- `readData1_E` in N: multiplicand.
- `readData2_E` in N: multiplier.
- `aluResult_E` in N: result from the shared execute ALU.
- `alu_own` out 1: 1 means the execute ALU operand and control muxes select this block's outputs.
- `aluA`, `aluB` out N: ALU operands.
- `aluCtl` out 4: ALU control.
- `stall` out 1: holds the IF, ID and EX pipeline registers.
- `mul_done` out 1: the result is valid this cycle.
- `mulResult` out N: product bits [N-1:0].

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - `acc` (N bits)
  - `mcand` (N bits; shifted left 1 per RUN cycle)
  - `mplier` (N bits; shifted right 1 per RUN cycle)
  - `cnt` (6 bits)
- IDLE:
  - If `mul_E` is 1 and `flush_E` is 0: load `acc`=0, `mcand`=`readData1_E`, `mplier`=`readData2_E`, `cnt`=0.
  - Next state is DONE if `readData2_E`==0, otherwise RUN.
- RUN, each cycle:
  - Outputs: `alu_own`=1, `aluA`=`acc`, `aluB`=`mcand`, `aluCtl`=`ALU_ADD`.
  - If `mplier[0]`=1, capture `aluResult_E` into `acc`; otherwise `acc` is unchanged.
  - Then `mcand`<<=1, `mplier`>>=1, `cnt`++.
  - Go to DONE when `cnt`==63 or (`mplier`>>1)==0.
- DONE, exactly one cycle:
  - `mul_done`=1, `mulResult`=`acc`, `stall`=0.
  - The pipeline advances the MUL and uses `mulResult` in place of `aluResult_E`.
  - Next state is IDLE.
- `stall` = (IDLE and `mul_E` and not `flush_E`) or RUN. It is combinational so the MUL is held in execute from its first cycle.
- Outside RUN: `alu_own`=0; `aluA`, `aluB`, `aluCtl` = 0.
- Outside DONE: `mul_done`=0; `mulResult`=0.
- Arithmetic is modulo 2^N: overflow bits are discarded and operands are unsigned. The low N bits are identical for signed operands.
- `flush_E`=1 in any state: next state is IDLE and `acc` is cleared. `stall` drops in the same cycle. No `mul_done` is produced.
- A new `mul_E` is not accepted in DONE. Back-to-back MULs start from IDLE on the next cycle.

## Timing
- Reset (`reset`=0, asynchronous): state=IDLE; `acc`, `mcand`, `mplier`, `cnt` = 0; all outputs 0. This applies mid-RUN as well.
- Latency: with the start accepted in cycle 0, and k = index of the multiplier's highest set bit plus 1:
  - k RUN cycles (1..64) follow cycle 0.
  - `mul_done` is asserted in cycle k+1.
  - Multiplier 0: `mul_done` in cycle 1.
- `stall` is high for cycles 0..k.
- `acc` updates on the clock edge ending each RUN cycle. `aluResult_E` must be combinational from `aluA`/`aluB` within the same cycle.

## Structure
- The shared package `exec_pkg` holds:
  - the state enum (IDLE, RUN, DONE)
  - the `ALU_ADD` constant
  - the width constant N
- The block instantiates no ALU; it reuses the existing execute `alu`.
- Natural sub-module: `mul_step_cnt`, a 6-bit counter with load, enable and terminal-count flag.

## Test plan
- 3 × 5 (`mplier`=101b): `stall` high for cycles 0–3 (start cycle plus 3 RUN cycles). `mul_done` in cycle 4 with `mulResult`=15. `alu_own`=1 only in cycles 1–3.
- 7 × 0: `stall` high in cycle 0 only, `mul_done` in cycle 1, `mulResult`=0, `alu_own` never 1.
- 0xFFFF_FFFF_FFFF_FFFF × 2: 2 RUN cycles, `mulResult`=0xFFFF_FFFF_FFFF_FFFE (wrap-around).
- 1 × 0x8000_0000_0000_0000: 64 RUN cycles, `mul_done` in cycle 65, `mulResult`=0x8000_0000_0000_0000; `cnt` terminal at 63.
- `flush_E` asserted in the third RUN cycle of 3 × 0xFF: state goes to IDLE, `stall` is 0 in that cycle, and there is no `mul_done`. A new 2 × 3 MUL then gives `mulResult`=6.
- `reset` pulled low mid-RUN, asynchronously between edges: all outputs go to 0 immediately and state=IDLE. After release, 4 × 4 gives 16.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: datapath width, ALU opcodes and the
// multiply sequencer state encoding.
package exec_pkg;

   localparam int N = 64;

   localparam logic [3:0] ALU_ADD = 4'b0010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage : exec_pkg

// File: rtl/mul_step_cnt.sv
// Six-bit step counter for the multiply sequencer. Counts processed
// multiplier bits and flags the last possible step (63).
module mul_step_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       en,
   output logic [5:0] cnt,
   output logic       tc
);

   // Load restarts the count from zero and takes priority over enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= 6'd0;
      end else if (load) begin
         cnt <= 6'd0;
      end else if (en) begin
         cnt <= cnt + 6'd1;
      end
   end

   assign tc = (cnt == 6'd63);

endmodule : mul_step_cnt

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier for the execute stage. Borrows the shared
// execute ALU for one add per multiplier bit and stalls the pipeline while
// it runs; the low N bits of the product are presented for one cycle.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a MUL in execute; start loads operands
//   RUN   | owns the ALU, one multiplier bit per cycle, pipeline stalled
//   DONE  | product valid for exactly one cycle, pipeline released
module exec_mul_seq
   import exec_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         mul_E,
   input  logic         flush_E,
   input  logic [N-1:0] readData1_E,
   input  logic [N-1:0] readData2_E,
   input  logic [N-1:0] aluResult_E,
   output logic         alu_own,
   output logic [N-1:0] aluA,
   output logic [N-1:0] aluB,
   output logic [3:0]   aluCtl,
   output logic         stall,
   output logic         mul_done,
   output logic [N-1:0] mulResult
);

   mul_state_t   state;
   logic [N-1:0] acc;
   logic [N-1:0] mcand;
   logic [N-1:0] mplier;
   logic [5:0]   cnt;
   logic         cnt_tc;
   logic         start;
   logic         last_step;

   assign start     = (state == IDLE) && mul_E && !flush_E;
   // Stop once the remaining multiplier bits are all zero, so short
   // multipliers finish early instead of always taking 64 steps.
   assign last_step = cnt_tc || (mplier[N-1:1] == '0);

   mul_step_cnt u_step_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (start || flush_E),
      .en    ((state == RUN) && !flush_E),
      .cnt   (cnt),
      .tc    (cnt_tc)
   );

   // Sequencer FSM and shift-add datapath registers; flush aborts from any state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (flush_E) begin
         state <= IDLE;
         acc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc    <= '0;
                  mcand  <= readData1_E;
                  mplier <= readData2_E;
                  state  <= (readData2_E == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (mplier[0]) begin
                  acc <= aluResult_E;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (last_step) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output decode from registered state. Stall is combinational so the MUL
   // is held from its first cycle; a flush releases it immediately and
   // suppresses a pending result. Reset forces every output low.
   always_comb begin
      alu_own   = 1'b0;
      aluA      = '0;
      aluB      = '0;
      aluCtl    = 4'b0000;
      stall     = 1'b0;
      mul_done  = 1'b0;
      mulResult = '0;
      if (reset) begin
         stall = start || ((state == RUN) && !flush_E);
         if (state == RUN) begin
            alu_own = 1'b1;
            aluA    = acc;
            aluB    = mcand;
            aluCtl  = ALU_ADD;
         end
         if ((state == DONE) && !flush_E) begin
            mul_done  = 1'b1;
            mulResult = acc;
         end
      end
   end

endmodule : exec_mul_seq

// File: tb/tb_exec_mul_seq.sv
// Directed and randomized bench for exec_mul_seq. The shared ALU is modelled
// as an adder; expectations come from plain arithmetic on the operands.
module tb_exec_mul_seq;

   logic        clk;
   logic        reset;
   logic        mul_E;
   logic        flush_E;
   logic [63:0] readData1_E;
   logic [63:0] readData2_E;
   logic [63:0] aluResult_E;
   logic        alu_own;
   logic [63:0] aluA;
   logic [63:0] aluB;
   logic [3:0]  aluCtl;
   logic        stall;
   logic        mul_done;
   logic [63:0] mulResult;

   int n_assert;
   int n_fail;

   exec_mul_seq dut (
      .clk         (clk),
      .reset       (reset),
      .mul_E       (mul_E),
      .flush_E     (flush_E),
      .readData1_E (readData1_E),
      .readData2_E (readData2_E),
      .aluResult_E (aluResult_E),
      .alu_own     (alu_own),
      .aluA        (aluA),
      .aluB        (aluB),
      .aluCtl      (aluCtl),
      .stall       (stall),
      .mul_done    (mul_done),
      .mulResult   (mulResult)
   );

   // Execute ALU: adds when asked to, otherwise returns junk.
   assign aluResult_E = (aluCtl == 4'b0010) ? (aluA + aluB) : 64'h0BAD_F00D_DEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".stall"},   64'(stall),    64'd0);
      chk({tag, ".own"},     64'(alu_own),  64'd0);
      chk({tag, ".aluA"},    aluA,          64'd0);
      chk({tag, ".aluB"},    aluB,          64'd0);
      chk({tag, ".aluCtl"},  64'(aluCtl),   64'd0);
      chk({tag, ".done"},    64'(mul_done), 64'd0);
      chk({tag, ".result"},  mulResult,     64'd0);
   endtask

   function automatic int top_k(input logic [63:0] b);
      for (int i = 63; i >= 0; i--) begin
         if (b[i]) return i + 1;
      end
      return 0;
   endfunction

   // One multiply: cycle 0 is the start cycle. flush_cyc/rst_cyc (>0) abort
   // the operation in that cycle.
   task automatic run_mul(input logic [63:0] a, input logic [63:0] b,
                          input int flush_cyc, input int rst_cyc, input string tag);
      int          k;
      logic [63:0] prod;
      logic [63:0] mask;
      k    = top_k(b);
      prod = a * b;
      @(negedge clk);
      mul_E = 1'b1; flush_E = 1'b0; readData1_E = a; readData2_E = b;
      #1;
      chk({tag, ".c0_stall"}, 64'(stall),    64'd1);
      chk({tag, ".c0_own"},   64'(alu_own),  64'd0);
      chk({tag, ".c0_done"},  64'(mul_done), 64'd0);
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         readData1_E = {$urandom, $urandom};
         readData2_E = {$urandom, $urandom};
         if (c == flush_cyc) begin
            flush_E = 1'b1;
            #1;
            chk({tag, ".flush_stall"}, 64'(stall),    64'd0);
            chk({tag, ".flush_done"},  64'(mul_done), 64'd0);
            @(negedge clk);
            flush_E = 1'b0; mul_E = 1'b0;
            #1;
            chk_all_zero({tag, ".post_flush"});
            return;
         end
         if (c == rst_cyc) begin
            #2;
            reset = 1'b0; mul_E = 1'b0;
            #1;
            chk_all_zero({tag, ".in_reset"});
            @(negedge clk);
            reset = 1'b1;
            #1;
            chk_all_zero({tag, ".post_reset"});
            return;
         end
         #1;
         if (c <= k) begin
            mask = (64'd1 << (c - 1)) - 64'd1;
            chk({tag, ".run_stall"},  64'(stall),    64'd1);
            chk({tag, ".run_own"},    64'(alu_own),  64'd1);
            chk({tag, ".run_aluA"},   aluA,          a * (b & mask));
            chk({tag, ".run_aluB"},   aluB,          a << (c - 1));
            chk({tag, ".run_aluCtl"}, 64'(aluCtl),   64'd2);
            chk({tag, ".run_done"},   64'(mul_done), 64'd0);
            chk({tag, ".run_result"}, mulResult,     64'd0);
         end else begin
            chk({tag, ".done_cycle"}, 64'(c),        64'(k + 1));
            chk({tag, ".done_stall"}, 64'(stall),    64'd0);
            chk({tag, ".done_own"},   64'(alu_own),  64'd0);
            chk({tag, ".done_flag"},  64'(mul_done), 64'd1);
            chk({tag, ".result"},     mulResult,     prod);
            @(negedge clk);
            mul_E = 1'b0;
            #1;
            chk_all_zero({tag, ".after_done"});
            return;
         end
      end
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      n_assert = 0;
      n_fail   = 0;
      reset = 1'b0; mul_E = 1'b0; flush_E = 1'b0;
      readData1_E = '0; readData2_E = '0;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_all_zero("idle");

      run_mul(64'd3, 64'd5, 0, 0, "m3x5");
      run_mul(64'd7, 64'd0, 0, 0, "m7x0");
      run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0, "wrap");
      run_mul(64'd1, 64'h8000_0000_0000_0000, 0, 0, "full64");
      run_mul(64'd3, 64'hFF, 3, 0, "flush");
      run_mul(64'd2, 64'd3, 0, 0, "m2x3");
      run_mul(64'd3, 64'hFF, 0, 4, "rstmid");
      run_mul(64'd4, 64'd4, 0, 0, "m4x4");

      for (int i = 0; i < 8; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom} >> $urandom_range(63, 0);
         run_mul(ra, rb, 0, 0, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_exec_mul_seq
